// File: rtl/add_64_bit_seq.sv
// rtl/add_64_bit_seq.sv - two-cycle 64-bit add/subtract built on one shared 32-bit CLA
// add_32_bit reports block propagate/generate so the caller can chain words.

module add_32_bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        c_in,
    output logic [31:0] s,
    output logic        p_out,
    output logic        g_out
);
    logic [31:0] p, g, c;
    logic [7:0]  gp, gg, gc;

    always_comb begin
        p = a ^ b;
        g = a & b;
        for (int k = 0; k < 8; k++) begin
            gp[k] = &p[4*k +: 4];
            gg[k] = g[4*k+3]
                  | (p[4*k+3] & g[4*k+2])
                  | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
        end
    end

    // Group carries look ahead across 4-bit groups; bits inside a group ripple.
    always_comb begin
        gc[0] = c_in;
        for (int k = 0; k < 7; k++) begin
            gc[k+1] = gg[k] | (gp[k] & gc[k]);
        end
        c = '0;
        for (int k = 0; k < 8; k++) begin
            c[4*k] = gc[k];
            for (int j = 0; j < 3; j++) begin
                c[4*k+j+1] = g[4*k+j] | (p[4*k+j] & c[4*k+j]);
            end
        end
        s = p ^ c;
    end

    always_comb begin
        g_out = 1'b0;
        for (int k = 0; k < 8; k++) begin
            g_out = gg[k] | (gp[k] & g_out);
        end
        p_out = &gp;
    end
endmodule

module add_64_bit_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        sub,
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        c_in,
    output logic        busy,
    output logic        done,
    output logic [63:0] s,
    output logic        c_out,
    output logic        overflow
);
    typedef enum logic [1:0] {IDLE, LOW, HIGH, FIN} state_t;

    state_t      state, state_next;
    logic [63:0] a_reg, b_reg;
    logic        carry_reg;
    logic        accept;
    logic [31:0] add_a, add_b, add_s;
    logic        add_p, add_g, add_cout;

    always_comb begin
        add_a    = (state == HIGH) ? a_reg[63:32] : a_reg[31:0];
        add_b    = (state == HIGH) ? b_reg[63:32] : b_reg[31:0];
        add_cout = add_g | (add_p & carry_reg);
    end

    add_32_bit u_add (
        .a     (add_a),
        .b     (add_b),
        .c_in  (carry_reg),
        .s     (add_s),
        .p_out (add_p),
        .g_out (add_g)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // FIN accepts a new start exactly like IDLE so operations can run back to back.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = LOW;
                end
            end
            LOW: begin
                busy       = 1'b1;
                state_next = HIGH;
            end
            HIGH: begin
                busy       = 1'b1;
                state_next = FIN;
            end
            FIN: begin
                done       = 1'b1;
                state_next = IDLE;
                if (start) begin
                    accept     = 1'b1;
                    state_next = LOW;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // carry_reg holds the initial carry until LOW, then the inter-word carry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            carry_reg <= 1'b0;
            s         <= '0;
            c_out     <= 1'b0;
            overflow  <= 1'b0;
        end else if (accept) begin
            a_reg     <= a;
            b_reg     <= sub ? ~b : b;
            carry_reg <= sub | c_in;
        end else if (state == LOW) begin
            s[31:0]   <= add_s;
            carry_reg <= add_cout;
        end else if (state == HIGH) begin
            s[63:32]  <= add_s;
            c_out     <= add_cout;
            overflow  <= (a_reg[63] == b_reg[63]) && (add_s[31] != a_reg[63]);
        end
    end
endmodule

// File: tb/tb_add_64_bit_seq.sv
// tb/tb_add_64_bit_seq.sv - directed and random checks of add_64_bit_seq against an arithmetic model

module tb_add_64_bit_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        sub;
    logic [63:0] a, b;
    logic        c_in;
    logic        busy, done;
    logic [63:0] s;
    logic        c_out, overflow;

    int errors = 0;
    int checks = 0;

    add_64_bit_seq dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .sub      (sub),
        .a        (a),
        .b        (b),
        .c_in     (c_in),
        .busy     (busy),
        .done     (done),
        .s        (s),
        .c_out    (c_out),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: exact 65-bit arithmetic and the signed-overflow rule on operand signs.
    task automatic model(input logic [63:0] ma, input logic [63:0] mb, input logic msub,
                         input logic mcin, output logic [63:0] es, output logic ec,
                         output logic eov);
        logic [64:0] wide;
        if (msub) begin
            wide = {1'b0, ma} + {1'b0, 64'hFFFF_FFFF_FFFF_FFFF - mb} + 65'd1;
            eov  = (ma[63] != mb[63]) && (wide[63] != ma[63]);
        end else begin
            wide = {1'b0, ma} + {1'b0, mb} + {64'd0, mcin};
            eov  = (ma[63] == mb[63]) && (wide[63] != ma[63]);
        end
        es = wide[63:0];
        ec = wide[64];
    endtask

    task automatic rand64(output logic [63:0] v);
        v = {$urandom, $urandom};
    endtask

    // Called at a negedge with the DUT idle; leaves it at the negedge after FIN.
    task automatic do_op(input string tag, input logic [63:0] oa, input logic [63:0] ob,
                         input logic osub, input logic ocin);
        logic [63:0] es;
        logic        ec, eov;
        logic [63:0] junk;
        model(oa, ob, osub, ocin, es, ec, eov);
        a = oa; b = ob; sub = osub; c_in = ocin; start = 1'b1;
        @(negedge clk);
        check({tag, " busy_low"}, {63'd0, busy}, 64'd1);
        check({tag, " done_low"}, {63'd0, done}, 64'd0);
        rand64(junk); a = junk; rand64(junk); b = junk;
        sub = ~osub; c_in = ~ocin;
        @(negedge clk);
        check({tag, " busy_high"}, {63'd0, busy}, 64'd1);
        start = 1'b0;
        @(negedge clk);
        check({tag, " done"}, {63'd0, done}, 64'd1);
        check({tag, " busy_fin"}, {63'd0, busy}, 64'd0);
        check({tag, " s"}, s, es);
        check({tag, " c_out"}, {63'd0, c_out}, {63'd0, ec});
        check({tag, " overflow"}, {63'd0, overflow}, {63'd0, eov});
        @(negedge clk);
        check({tag, " done_clear"}, {63'd0, done}, 64'd0);
        check({tag, " s_hold"}, s, es);
    endtask

    logic [63:0] oa [12];
    logic [63:0] ob [12];
    logic        os [12];
    logic        oc [12];

    initial begin
        logic [63:0] ra, rb, es;
        logic        ec, eov;

        rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0; c_in = 1'b0;
        #1;
        check("rst s", s, 64'd0);
        check("rst busy", {63'd0, busy}, 64'd0);
        check("rst done", {63'd0, done}, 64'd0);
        check("rst c_out", {63'd0, c_out}, 64'd0);
        check("rst overflow", {63'd0, overflow}, 64'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        do_op("basic", 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
        check("basic const", s, 64'h0000_0001_0000_0000);
        do_op("wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 1'b1);
        check("wrap const", s, 64'd0);
        check("wrap c_out const", {63'd0, c_out}, 64'd1);
        do_op("ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
        check("ovf const", {63'd0, overflow}, 64'd1);
        do_op("sub", 64'd5, 64'd7, 1'b1, 1'b0);
        check("sub const", s, 64'hFFFF_FFFF_FFFF_FFFE);
        check("sub c_out const", {63'd0, c_out}, 64'd0);
        do_op("sub_cin_ign", 64'd9, 64'd4, 1'b1, 1'b1);
        do_op("sub_min_ovf", 64'h8000_0000_0000_0000, 64'd1, 1'b1, 1'b0);

        for (int i = 0; i < 8; i++) begin
            rand64(ra); rand64(rb);
            do_op("rand", ra, rb, 1'($urandom_range(1)), 1'($urandom_range(1)));
        end

        // Start held high: accepts on every third edge, each result from its own operands.
        for (int i = 0; i < 12; i++) begin
            rand64(ra); rand64(rb);
            oa[i] = ra; ob[i] = rb;
            os[i] = 1'($urandom_range(1)); oc[i] = 1'($urandom_range(1));
            a = oa[i]; b = ob[i]; sub = os[i]; c_in = oc[i]; start = 1'b1;
            @(negedge clk);
            check("b2b done", {63'd0, done}, {63'd0, (i % 3) == 2});
            check("b2b busy", {63'd0, busy}, {63'd0, (i % 3) != 2});
            if ((i % 3) == 2) begin
                model(oa[i-2], ob[i-2], os[i-2], oc[i-2], es, ec, eov);
                check("b2b s", s, es);
                check("b2b c_out", {63'd0, c_out}, {63'd0, ec});
                check("b2b overflow", {63'd0, overflow}, {63'd0, eov});
            end
        end
        start = 1'b0;
        @(negedge clk);
        check("b2b idle", {63'd0, busy | done}, 64'd0);

        // Abort during HIGH.
        a = 64'd1; b = 64'd1; sub = 1'b0; c_in = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("abort in_high", {63'd0, busy}, 64'd1);
        rst = 1'b1;
        #1;
        check("abort s", s, 64'd0);
        check("abort busy", {63'd0, busy}, 64'd0);
        check("abort done", {63'd0, done}, 64'd0);
        check("abort c_out", {63'd0, c_out | overflow}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort no_done", {63'd0, done | busy}, 64'd0);
        end

        do_op("after_abort", 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
